// File: rtl/tetris_pkg.sv
// ---------------------------------------------------------------------------
// tetris_pkg
// Shared scan-code constants, decoder state type, key-vector indices and the
// scan-code -> key lookup used by ps2_key_decoder.
// Build option: TETRIS_WASD_EN adds A/D/S/W as alternate movement keys.
// No ports (package).
// ---------------------------------------------------------------------------
package tetris_pkg;

  // Prefix bytes (scan-code set 2)
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;

  // Mapped key codes
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_W      = 8'h1D;

  // Controller status bytes that carry no key information
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_BAT_ER = 8'hFC;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  // Controller error bytes
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE_SKIP
  } ps2_state_t;

  // Bit positions in the 5-bit key vector
  localparam int         NUM_KEYS   = 5;
  localparam logic [2:0] KEY_LEFT   = 3'd0;
  localparam logic [2:0] KEY_RIGHT  = 3'd1;
  localparam logic [2:0] KEY_DOWN   = 3'd2;
  localparam logic [2:0] KEY_ROTATE = 3'd3;
  localparam logic [2:0] KEY_DROP   = 3'd4;

  // wasd marks a hit coming from the alternate (letter) source
  typedef struct packed {
    logic       hit;
    logic       wasd;
    logic [2:0] index;
  } keymap_t;

  // Extended and base tables are disjoint, so the ext flag selects the table.
  function automatic keymap_t keymap(input logic [7:0] code, input logic ext);
    keymap_t r;
    r = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  begin r.hit = 1'b1; r.index = KEY_LEFT;   end
        SC_RIGHT: begin r.hit = 1'b1; r.index = KEY_RIGHT;  end
        SC_DOWN:  begin r.hit = 1'b1; r.index = KEY_DOWN;   end
        SC_UP:    begin r.hit = 1'b1; r.index = KEY_ROTATE; end
        default:  r = '0;
      endcase
    end else begin
      case (code)
        SC_SPACE: begin r.hit = 1'b1; r.index = KEY_DROP; end
`ifdef TETRIS_WASD_EN
        SC_A: begin r.hit = 1'b1; r.wasd = 1'b1; r.index = KEY_LEFT;   end
        SC_D: begin r.hit = 1'b1; r.wasd = 1'b1; r.index = KEY_RIGHT;  end
        SC_S: begin r.hit = 1'b1; r.wasd = 1'b1; r.index = KEY_DOWN;   end
        SC_W: begin r.hit = 1'b1; r.wasd = 1'b1; r.index = KEY_ROTATE; end
`endif
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
// Bundles the byte stream from the PS/2 receiver and the held-key levels sent
// to the game logic.
//   scan_code/scan_valid : byte strobe from the receiver
//   key_left..key_drop   : held key levels
//   key_event            : pulse when any key level changes
//   proto_err            : pulse on timeout or controller error byte
// Modports: master = byte source / key consumer, slave = the decoder.
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       key_left;
  logic       key_right;
  logic       key_down;
  logic       key_rotate;
  logic       key_drop;
  logic       key_event;
  logic       proto_err;

  modport master (
    output scan_code, scan_valid,
    input  key_left, key_right, key_down, key_rotate, key_drop,
    input  key_event, proto_err
  );

  modport slave (
    input  scan_code, scan_valid,
    output key_left, key_right, key_down, key_rotate, key_drop,
    output key_event, proto_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Turns PS/2 set-2 bytes into held key levels for the game state machine.
// Handles E0/F0 prefixes, swallows the 8-byte Pause sequence and status
// bytes, and drops back to IDLE if a prefix is left hanging too long.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : ps2_key_decoder_if.slave (scan byte in, key levels/pulses out)
// Parameter PREFIX_TIMEOUT : idle cycles tolerated outside IDLE (>= 2).
// Build option: TETRIS_WASD_EN adds A/D/S/W as a second movement source.
// ---------------------------------------------------------------------------
module ps2_key_decoder
  import tetris_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  ps2_key_decoder_if.slave   bus
);

  localparam int TO_W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

  ps2_state_t          state_q;
  logic [2:0]          skipCnt_q;
  logic [TO_W-1:0]     toCnt_q;
  logic [NUM_KEYS-1:0] arrow_q, arrow_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic                keyEvent_q;
  logic                protoErr_q;
  logic                isMake, isBreak, isExt, ctrlByte;
  keymap_t             km;

`ifdef TETRIS_WASD_EN
  logic [3:0]          wasd_q, wasd_d;
`endif

  // Classify the current byte as make/break of a base or extended code and
  // compute the next held-key vector from it.
  always_comb begin
    isMake  = 1'b0;
    isBreak = 1'b0;
    isExt   = 1'b0;
    case (bus.scan_code)
      SC_EXT, SC_BRK, SC_PAUSE, SC_BAT_OK, SC_ACK, SC_ECHO,
      SC_BAT_ER, SC_RESEND, SC_ERR_LO, SC_ERR_HI: ctrlByte = 1'b1;
      default:                                   ctrlByte = 1'b0;
    endcase
    if (bus.scan_valid) begin
      case (state_q)
        ST_IDLE:    isMake = !ctrlByte;
        ST_EXT: begin
          isMake = (bus.scan_code != SC_EXT) && (bus.scan_code != SC_BRK);
          isExt  = 1'b1;
        end
        ST_BRK:     isBreak = 1'b1;
        ST_EXT_BRK: begin
          isBreak = 1'b1;
          isExt   = 1'b1;
        end
        default:    isMake = 1'b0;
      endcase
    end
    km = keymap(bus.scan_code, isExt);
    arrow_d = arrow_q;
    if ((isMake || isBreak) && km.hit && !km.wasd)
      arrow_d[km.index] = isMake;
`ifdef TETRIS_WASD_EN
    wasd_d = wasd_q;
    if ((isMake || isBreak) && km.hit && km.wasd)
      wasd_d[km.index[1:0]] = isMake;
    keys_d = arrow_d | {1'b0, wasd_d};
`else
    keys_d = arrow_d;
`endif
  end

  // Prefix FSM, Pause skipper, prefix timeout and registered outputs.
  // key_event compares against the previous combined vector, so typematic
  // repeats and releases masked by the other source stay silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      skipCnt_q  <= '0;
      toCnt_q    <= '0;
      arrow_q    <= '0;
      keys_q     <= '0;
      keyEvent_q <= 1'b0;
      protoErr_q <= 1'b0;
`ifdef TETRIS_WASD_EN
      wasd_q     <= '0;
`endif
    end else begin
      arrow_q    <= arrow_d;
`ifdef TETRIS_WASD_EN
      wasd_q     <= wasd_d;
`endif
      keys_q     <= keys_d;
      keyEvent_q <= (keys_d != keys_q);
      protoErr_q <= 1'b0;
      if (bus.scan_valid) begin
        toCnt_q <= '0;
        case (state_q)
          ST_IDLE: begin
            case (bus.scan_code)
              SC_EXT:   state_q <= ST_EXT;
              SC_BRK:   state_q <= ST_BRK;
              SC_PAUSE: begin
                state_q   <= ST_PAUSE_SKIP;
                skipCnt_q <= 3'd7;
              end
              SC_ERR_LO, SC_ERR_HI: protoErr_q <= 1'b1;
              default:  state_q <= ST_IDLE;
            endcase
          end
          ST_EXT: begin
            if (bus.scan_code == SC_BRK)      state_q <= ST_EXT_BRK;
            else if (bus.scan_code == SC_EXT) state_q <= ST_EXT;
            else                              state_q <= ST_IDLE;
          end
          ST_PAUSE_SKIP: begin
            skipCnt_q <= skipCnt_q - 3'd1;
            if (skipCnt_q <= 3'd1) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (toCnt_q == TO_LAST) begin
          state_q    <= ST_IDLE;
          skipCnt_q  <= '0;
          toCnt_q    <= '0;
          protoErr_q <= 1'b1;
        end else begin
          toCnt_q <= toCnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.key_left   = keys_q[KEY_LEFT];
  assign bus.key_right  = keys_q[KEY_RIGHT];
  assign bus.key_down   = keys_q[KEY_DOWN];
  assign bus.key_rotate = keys_q[KEY_ROTATE];
  assign bus.key_drop   = keys_q[KEY_DROP];
  assign bus.key_event  = keyEvent_q;
  assign bus.proto_err  = protoErr_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Converts the byte stream from the PS/2 receiver (scan-code set 2) into held-key levels for the game logic: key_left, key_right, key_down, key_rotate and key_drop. It sits directly upstream of the game state machine, which edge-detects these levels. It tracks the make/break and extended prefixes, discards the Pause sequence and controller status bytes, and recovers from stray prefixes with a timeout.

Parameters:
PREFIX_TIMEOUT, 1_000_000, clk cycles allowed in any non-IDLE state without a new byte before forcing IDLE (10 ms at 100 MHz); must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
scan_code  in  8  received byte, valid only when scan_valid=1
scan_valid  in  1  one-cycle strobe, at most one byte per cycle
key_left  out  1  held level, Left arrow (E0 6B)
key_right  out  1  held level, Right arrow (E0 74)
key_down  out  1  held level, Down arrow (E0 72)
key_rotate  out  1  held level, Up arrow (E0 75)
key_drop  out  1  held level, Space (29)
key_event  out  1  one-cycle pulse when any key_* output changes
proto_err  out  1  one-cycle pulse on timeout or on controller error byte 00/FF

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high. On rst: all key_* = 0, key_event = 0, proto_err = 0, state = IDLE, skip_cnt = 0, timeout counter = 0. Reset mid-sequence discards any partial prefix.
- Latency: key_* and key_event are registered and update on the clk edge that consumes the final byte of a sequence. They are visible one cycle after the scan_valid cycle.
- States: IDLE, EXT, BRK, EXT_BRK, PAUSE_SKIP. Transitions occur only on scan_valid, except for the timeout.
- IDLE:
  - E0 -> EXT; F0 -> BRK; E1 -> PAUSE_SKIP with skip_cnt = 7.
  - AA, FA, EE, FC, FE -> ignored, stay in IDLE.
  - 00 or FF -> proto_err pulse, stay in IDLE.
  - Any other byte -> make of the base code.
- EXT:
  - F0 -> EXT_BRK; E0 -> stay in EXT.
  - Any other byte -> make of the extended code, then IDLE. Fake-shift E0 12 is unmapped and therefore ignored.
- BRK: any byte -> break of the base code -> IDLE.
- EXT_BRK: any byte -> break of the extended code -> IDLE.
- PAUSE_SKIP: decrement skip_cnt on each byte; on the byte that reaches 0 -> IDLE. No key changes in this state.
- Make sets the mapped bit to 1; break clears it to 0. Unmapped codes change nothing and return to IDLE.
- Typematic repeats (a make while the key is already held) leave the level at 1 and produce no key_event.
- key_event = 1 only when the registered key vector differs from its previous value.
- Timeout:
  - The counter resets on every scan_valid and counts while state != IDLE.
  - On reaching PREFIX_TIMEOUT-1: state -> IDLE, proto_err pulses, key levels are unchanged.
  - In IDLE the counter holds at 0.
- Extended and base maps are disjoint: E0 29 does not assert key_drop, and a bare 6B does not assert key_left.

Optional Feature:
- Macro: TETRIS_WASD_EN.
- When defined: base codes 1C (A) = left, 23 (D) = right, 1B (S) = down, 1D (W) = rotate also drive the outputs.
  - Held state is kept separately for the arrow source and the WASD source; each output is the OR of its two sources.
  - Releasing one source while the other is held keeps the output at 1, with no key_event.
- When undefined: 1C, 23, 1B and 1D are unmapped, and no WASD state registers exist.

Decomposition:
- Shared package tetris_pkg holds:
  - scan-code localparams: SC_EXT = E0, SC_BRK = F0, SC_PAUSE = E1, SC_SPACE = 29, SC_LEFT = 6B, SC_RIGHT = 74, SC_DOWN = 72, SC_UP = 75, and the WASD codes;
  - ps2_state_t enum;
  - key-index constants (KEY_LEFT..KEY_DROP) for a 5-bit key vector.
- A pure function keymap(code, ext) -> {hit, index} also lives in the package. No sub-module is needed; the bit-level PS/2 receiver is a separate upstream block.

Test Plan:
- Bytes E0, 6B, 1 cycle apart -> key_left = 1 one cycle after the 6B strobe, key_event pulses once. Then E0, F0, 6B -> key_left = 0, key_event pulses.
- Byte 29, then 29 repeated 5x (typematic), then F0, 29 -> key_drop rises once, stays 1 with no further key_event, then falls to 0 after the 29 that follows F0.
- E1 14 77 E1 F0 14 F0 77 (Pause) -> no key_* change, state returns to IDLE. A following E0 75 sets key_rotate = 1.
- Lone E0, then no byte for PREFIX_TIMEOUT cycles (set to 16) -> proto_err pulses at cycle 16, state = IDLE. A following 6B leaves key_left = 0.
- Hold E0 74 and 29 together, assert rst for one cycle -> all key_* = 0 on the next cycle. Then F0, 29 produces no key_event.
- With TETRIS_WASD_EN: 1C then E0 6B, then F0 1C -> key_left stays 1; then E0 F0 6B -> key_left = 0 with exactly one key_event.
